// File: rtl/systolic_matrix_loader.sv
// Stream-to-bank loader for the systolic matmul core: fills A then B (row-major),
// fires load_en, waits for cal_finish (with optional watchdog), then releases.
module systolic_matrix_loader #(
  parameter int DWIDTH  = 64,
  parameter int N       = 12,
  parameter int TIMEOUT = 65535
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             abort,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DWIDTH-1:0]                in_data,
  output logic [N-1:0][N-1:0][DWIDTH-1:0]  a_row,
  output logic [N-1:0][N-1:0][DWIDTH-1:0]  b_col,
  output logic                             load_en,
  input  logic                             cal_finish,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic [2:0]                       dbg_state
);

  // Stream handshake: an element transfers on a clk edge where in_valid & in_ready.
  // in_ready decodes only the state register, so there is no valid->ready path.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_FIRE    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam int             IW       = $clog2(N);
  localparam logic [IW-1:0]  IDX_LAST = IW'(N - 1);
  localparam int             WDW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);

  state_t                            state_q, state_d;
  logic [IW-1:0]                     row_q, row_d;
  logic [IW-1:0]                     col_q, col_d;
  logic [WDW-1:0]                    wd_q, wd_d;
  logic                              err_q, err_d;
  logic [N-1:0][N-1:0][DWIDTH-1:0]   a_row_q;
  logic [N-1:0][N-1:0][DWIDTH-1:0]   b_col_q;

  logic hs;
  logic last_elem;
  logic wd_expired;

  assign hs         = in_valid & in_ready;
  assign last_elem  = (row_q == IDX_LAST) && (col_q == IDX_LAST);
  assign wd_expired = (TIMEOUT != 0) && (wd_q == WD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    wd_d    = wd_q;
    err_d   = err_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD_A;
            row_d   = '0;
            col_d   = '0;
            wd_d    = '0;
            err_d   = 1'b0;
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          if (hs) begin
            if (col_q == IDX_LAST) begin
              col_d = '0;
              row_d = (row_q == IDX_LAST) ? '0 : row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
            if (last_elem) begin
              state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_FIRE;
              wd_d    = '0;
            end
          end
        end
        S_FIRE: begin
          wd_d = wd_q + 1'b1;
          // A completion in the same cycle as expiry counts as success.
          if (cal_finish) begin
            state_d = S_RELEASE;
          end else if (wd_expired) begin
            state_d = S_RELEASE;
            err_d   = 1'b1;
          end
        end
        S_RELEASE: state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
    load_en   = (state_q == S_FIRE);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_RELEASE) && !err_q;
    err       = err_q;
    dbg_state = state_q;
  end

  // Banks are written only on an accepted element; abort suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_row_q <= '0;
      b_col_q <= '0;
    end else if (hs && !abort) begin
      if (state_q == S_LOAD_A) begin
        a_row_q[row_q][col_q] <= in_data;
      end else begin
        b_col_q[row_q][col_q] <= in_data;
      end
    end
  end

  assign a_row = a_row_q;
  assign b_col = b_col_q;

endmodule

// File: tb/tb_systolic_matrix_loader.sv
// Directed bench: N=2 loader (with and without a 10-cycle watchdog) and an N=12 reset test.
module tb_systolic_matrix_loader;

  localparam int DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the two N=2 instances
  logic rst_n, start, abort, in_valid, cal_finish;
  logic [DW-1:0] in_data;

  logic [1:0][1:0][DW-1:0] a_row_a, b_col_a, a_row_t, b_col_t;
  logic in_ready_a, load_en_a, busy_a, done_a, err_a;
  logic in_ready_t, load_en_t, busy_t, done_t, err_t;
  logic [2:0] dbg_a, dbg_t;

  logic rst12_n, start12, abort12, valid12, cal12;
  logic [DW-1:0] data12;
  logic [11:0][11:0][DW-1:0] a_row_12, b_col_12;
  logic in_ready_12, load_en_12, busy_12, done_12, err_12;
  logic [2:0] dbg_12;

  systolic_matrix_loader #(.DWIDTH(DW), .N(2), .TIMEOUT(65535)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .a_row(a_row_a), .b_col(b_col_a), .load_en(load_en_a), .cal_finish(cal_finish),
    .busy(busy_a), .done(done_a), .err(err_a), .dbg_state(dbg_a));

  systolic_matrix_loader #(.DWIDTH(DW), .N(2), .TIMEOUT(10)) dut_t (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready_t), .in_data(in_data),
    .a_row(a_row_t), .b_col(b_col_t), .load_en(load_en_t), .cal_finish(cal_finish),
    .busy(busy_t), .done(done_t), .err(err_t), .dbg_state(dbg_t));

  systolic_matrix_loader #(.DWIDTH(DW), .N(12), .TIMEOUT(65535)) dut_12 (
    .clk(clk), .rst_n(rst12_n), .start(start12), .abort(abort12),
    .in_valid(valid12), .in_ready(in_ready_12), .in_data(data12),
    .a_row(a_row_12), .b_col(b_col_12), .load_en(load_en_12), .cal_finish(cal12),
    .busy(busy_12), .done(done_12), .err(err_12), .dbg_state(dbg_12));

  int n_checks = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] vals[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic push_basic();
    for (int i = 0; i < 8; i++) exp_q.push_back(vals[i]);
  endtask

  // Pops A[0][0],A[0][1],A[1][0],A[1][1] then B in the same order.
  task automatic check_banks_a(input string tag);
    logic [DW-1:0] e;
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      if (i < 4) check($sformatf("%s_a%0d%0d", tag, i / 2, i % 2), a_row_a[i/2][i%2], e);
      else       check($sformatf("%s_b%0d%0d", tag, (i-4) / 2, i % 2), b_col_a[(i-4)/2][i%2], e);
    end
  endtask

  task automatic finish_ok(input string tag);
    cal_finish = 1'b1;
    step();
    cal_finish = 1'b0;
    check({tag, "_load_en_drop"}, 64'(load_en_a), 64'd0);
    check({tag, "_done"}, 64'(done_a), 64'd1);
    check({tag, "_busy_rel"}, 64'(busy_a), 64'd1);
    step();
    check({tag, "_busy_idle"}, 64'(busy_a), 64'd0);
    check({tag, "_done_once"}, 64'(done_a), 64'd0);
  endtask

  task automatic send12(input logic [DW-1:0] d);
    valid12 = 1'b1;
    data12  = d;
    step();
    valid12 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vals[0] = $realtobits(1.0); vals[1] = $realtobits(2.0);
    vals[2] = $realtobits(3.0); vals[3] = $realtobits(4.0);
    vals[4] = $realtobits(5.0); vals[5] = $realtobits(6.0);
    vals[6] = $realtobits(7.0); vals[7] = $realtobits(8.0);
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; cal_finish = 1'b0;
    in_data = '0;
    rst12_n = 1'b0; start12 = 1'b0; abort12 = 1'b0; valid12 = 1'b0; cal12 = 1'b0;
    data12 = '0;
    step(); step();
    rst_n = 1'b1; rst12_n = 1'b1;

    // Reset state
    check("rst_in_ready", 64'(in_ready_a), 64'd0);
    check("rst_load_en", 64'(load_en_a), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_err", 64'(err_a), 64'd0);
    check("rst_banks", 64'(|{a_row_a, b_col_a}), 64'd0);

    // Basic load
    pulse_start();
    check("basic_in_ready", 64'(in_ready_a), 64'd1);
    check("basic_busy", 64'(busy_a), 64'd1);
    for (int i = 0; i < 7; i++) send(vals[i]);
    check("basic_no_early_fire", 64'(load_en_a), 64'd0);
    send(vals[7]);
    check("basic_load_en_rise", 64'(load_en_a), 64'd1);
    check("basic_in_ready_low", 64'(in_ready_a), 64'd0);
    push_basic();
    check_banks_a("basic");
    for (int i = 0; i < 19; i++) step();
    check("basic_load_en_hold", 64'(load_en_a), 64'd1);
    finish_ok("basic");

    // Backpressure: valid 1,0,0 per element, garbage on data while idle
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      send(vals[i]);
      if (i < 7) begin
        in_data = 64'hDEAD_BEEF_0BAD_F00D;
        step();
        check($sformatf("bp_no_fire_%0d", i), 64'(load_en_a), 64'd0);
        step();
      end
    end
    check("bp_load_en_rise", 64'(load_en_a), 64'd1);
    push_basic();
    check_banks_a("bp");
    finish_ok("bp");

    // Watchdog timeout on dut_t (TIMEOUT=10)
    pulse_start();
    check("to_err_cleared", 64'(err_t), 64'd0);
    for (int i = 0; i < 8; i++) send(vals[i]);
    check("to_fire", 64'(load_en_t), 64'd1);
    for (int i = 0; i < 9; i++) step();
    check("to_fire_cycle10", 64'(load_en_t), 64'd1);
    step();
    check("to_load_en_drop", 64'(load_en_t), 64'd0);
    check("to_err_set", 64'(err_t), 64'd1);
    check("to_no_done", 64'(done_t), 64'd0);
    step();
    check("to_idle", 64'(busy_t), 64'd0);
    check("to_err_sticky", 64'(err_t), 64'd1);
    check("to_no_done2", 64'(done_t), 64'd0);
    pulse_abort();
    check("to_err_after_abort", 64'(err_t), 64'd1);
    check("to_a_aborted", 64'(busy_a), 64'd0);
    pulse_start();
    check("to_err_start_clr", 64'(err_t), 64'd0);
    check("to_restart", 64'(in_ready_t), 64'd1);
    pulse_abort();

    // Abort mid-load after 3 A elements
    pulse_start();
    send(64'd11); send(64'd12); send(64'd13);
    pulse_abort();
    check("ab_idle", 64'(busy_a), 64'd0);
    check("ab_in_ready", 64'(in_ready_a), 64'd0);
    check("ab_load_en", 64'(load_en_a), 64'd0);
    check("ab_done", 64'(done_a), 64'd0);
    check("ab_a00", a_row_a[0][0], 64'd11);
    check("ab_a01", a_row_a[0][1], 64'd12);
    check("ab_a10", a_row_a[1][0], 64'd13);
    check("ab_a11_kept", a_row_a[1][1], vals[3]);
    pulse_start();
    for (int i = 0; i < 8; i++) send(vals[i]);
    check("ab_refire", 64'(load_en_a), 64'd1);
    push_basic();
    check_banks_a("ab");
    finish_ok("ab");

    // Spurious and overlapping events
    cal_finish = 1'b1; step(); cal_finish = 1'b0;
    check("sp_cal_idle_busy", 64'(busy_a), 64'd0);
    check("sp_cal_idle_done", 64'(done_a), 64'd0);
    start = 1'b1; cal_finish = 1'b1; step(); start = 1'b0; cal_finish = 1'b0;
    check("sp_start_wins", 64'(in_ready_a), 64'd1);
    cal_finish = 1'b1; step(); cal_finish = 1'b0;
    check("sp_cal_loada", 64'(in_ready_a), 64'd1);
    check("sp_cal_loada_le", 64'(load_en_a), 64'd0);
    for (int i = 0; i < 6; i++) send(vals[i]);
    pulse_start();
    check("sp_start_loadb", 64'(in_ready_a), 64'd1);
    send(vals[6]); send(vals[7]);
    check("sp_fire", 64'(load_en_a), 64'd1);
    pulse_start();
    check("sp_start_fire", 64'(load_en_a), 64'd1);
    abort = 1'b1; cal_finish = 1'b1; step(); abort = 1'b0; cal_finish = 1'b0;
    check("sp_abort_cal_idle", 64'(busy_a), 64'd0);
    check("sp_abort_cal_le", 64'(load_en_a), 64'd0);
    check("sp_abort_cal_done", 64'(done_a), 64'd0);
    step();
    check("sp_abort_cal_done2", 64'(done_a), 64'd0);

    // Reset mid-FIRE on N=12
    start12 = 1'b1; step(); start12 = 1'b0;
    for (int i = 0; i < 288; i++) send12(64'(i + 1));
    check("r12_fire", 64'(load_en_12), 64'd1);
    check("r12_a00", a_row_12[0][0], 64'd1);
    check("r12_a35", a_row_12[3][5], 64'd42);
    check("r12_a1111", a_row_12[11][11], 64'd144);
    check("r12_b00", b_col_12[0][0], 64'd145);
    check("r12_b1111", b_col_12[11][11], 64'd288);
    step(); step(); step();
    rst12_n = 1'b0; step(); rst12_n = 1'b1;
    check("r12_load_en", 64'(load_en_12), 64'd0);
    check("r12_busy", 64'(busy_12), 64'd0);
    check("r12_in_ready", 64'(in_ready_12), 64'd0);
    check("r12_done_err", 64'({done_12, err_12}), 64'd0);
    check("r12_banks_zero", 64'(|{a_row_12, b_col_12}), 64'd0);
    step();
    check("r12_gap", 64'(load_en_12), 64'd0);
    start12 = 1'b1; step(); start12 = 1'b0;
    check("r12_restart_le", 64'(load_en_12), 64'd0);
    check("r12_restart_rdy", 64'(in_ready_12), 64'd1);
    for (int i = 0; i < 288; i++) send12(64'(1000 + i));
    check("r12_refire", 64'(load_en_12), 64'd1);
    check("r12_b_last", b_col_12[11][11], 64'd1287);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
